// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared types and default configuration for the UART receive control path.
//
// Contents:
//   CLKS_PER_BIT_DEF  default clocks per serial bit (must match the timer)
//   MID_START_DEF     default start-bit validation point, in clocks
//   rx_state_t        receive controller state encoding
//   rx_state_busy()   true while a frame is being processed
//
// START_CHK is only reachable when the design is built with the
// RX_START_VALIDATE_EN macro defined; it stays in the enum so the encoding
// is identical in both builds.
// ---------------------------------------------------------------------------
package rx_pkg;

   localparam int CLKS_PER_BIT_DEF = 10;
   localparam int MID_START_DEF    = 5;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_CHK = 3'd1,
      RECEIVE   = 3'd2,
      STOP_CHK  = 3'd3,
      LOAD      = 3'd4
   } rx_state_t;

   // A frame is in flight in every state except IDLE.
   function automatic logic rx_state_busy(input rx_state_t state);
      return (state != IDLE);
   endfunction

endpackage

// File: rtl/sync_high.sv
// ---------------------------------------------------------------------------
// sync_high
// Two-flop synchronizer for an asynchronous input whose idle level is high.
// Both flops reset to 1 so that releasing reset never produces a spurious
// falling edge on an idle line.
//
// Ports:
//   clk       in   system clock
//   n_rst     in   asynchronous active-low reset
//   async_in  in   asynchronous input
//   sync_out  out  input synchronized to clk (two-clock latency)
// ---------------------------------------------------------------------------
module sync_high (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/rx_ctrl.sv
// ---------------------------------------------------------------------------
// rx_ctrl
// Receive control unit of the UART receiver. Synchronizes the serial line,
// detects the start-bit falling edge, runs the bit timer for one frame,
// checks the stop bit, pulses the buffer load and maintains the sticky
// host-side status flags.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (must match the timer rollover)
//   MID_START     clocks after the start edge at which the start bit is
//                 re-sampled (only used with RX_START_VALIDATE_EN)
//
// Ports:
//   clk            in   system clock
//   n_rst          in   asynchronous active-low reset
//   serial_in      in   raw asynchronous serial line, idle high
//   packet_done    in   timer: 9 shift strobes elapsed since enable
//   stop_bit       in   stop-bit value, valid while packet_done is high
//   data_read      in   host acknowledge, single-cycle pulse
//   enable_timer   out  timer run/clear (timer counts only while high)
//   load_buffer    out  single-cycle pulse, copy shift reg to rx buffer
//   data_ready     out  sticky, receive buffer holds unread data
//   framing_error  out  sticky, last frame had a zero stop bit
//   overrun_error  out  sticky, a load happened while data_ready was set
//
// Build option:
//   RX_START_VALIDATE_EN  when defined, a START_CHK state re-samples the
//                         line after the start edge and rejects start
//                         pulses shorter than MID_START clocks.
// ---------------------------------------------------------------------------
module rx_ctrl
   import rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int MID_START    = MID_START_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic serial_in,
   input  logic packet_done,
   input  logic stop_bit,
   input  logic data_read,
   output logic enable_timer,
   output logic load_buffer,
   output logic data_ready,
   output logic framing_error,
   output logic overrun_error
);

   // The start-bit sample point has to land inside the start bit, and the
   // validation counter needs at least one clock in START_CHK.
   localparam bit CFG_OK = (MID_START >= 2) && (MID_START < CLKS_PER_BIT);

   generate
      if (!CFG_OK) begin : g_bad_cfg
         $error("rx_ctrl: MID_START must lie in [2, CLKS_PER_BIT-1]");
      end
   endgenerate

   rx_state_t state_q;
   rx_state_t state_d;

   logic rx_sync;
   logic prev_sync_q;
   logic prev_sync_d;
   logic start_edge;

   logic stop_q;
   logic stop_d;
   logic data_ready_q;
   logic data_ready_d;
   logic framing_error_q;
   logic framing_error_d;
   logic overrun_error_q;
   logic overrun_error_d;

`ifdef RX_START_VALIDATE_EN
   // The start-edge cycle itself is counted as the first clock, so the
   // line is re-sampled in the START_CHK cycle where the count reaches
   // MID_START-1, i.e. MID_START clocks into the synchronized start bit.
   localparam int CNT_W = $clog2(MID_START + 1);
   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MID_START - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
`endif

   sync_high u_sync (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (serial_in),
      .sync_out (rx_sync)
   );

   // One extra flop behind the synchronizer gives a clean falling-edge
   // detect; it resets high along with the synchronizer.
   assign prev_sync_d = rx_sync;
   assign start_edge  = prev_sync_q & ~rx_sync;

   // Next-state and status update. A host read clears data_ready and
   // overrun_error first; a load in the same cycle then re-asserts
   // data_ready but cannot raise overrun_error because the old data was
   // consumed on that very edge.
   always_comb begin
      state_d         = state_q;
      stop_d          = stop_q;
      data_ready_d    = data_ready_q;
      framing_error_d = framing_error_q;
      overrun_error_d = overrun_error_q;
`ifdef RX_START_VALIDATE_EN
      cnt_d           = cnt_q;
`endif

      if (data_read) begin
         data_ready_d    = 1'b0;
         overrun_error_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start_edge) begin
`ifdef RX_START_VALIDATE_EN
               state_d = START_CHK;
               cnt_d   = CNT_FIRST;
`else
               state_d         = RECEIVE;
               framing_error_d = 1'b0;
`endif
            end
         end

`ifdef RX_START_VALIDATE_EN
         START_CHK: begin
            if (cnt_q == CNT_LAST) begin
               // Line back high at the sample point: it was a glitch,
               // drop it without touching any status.
               if (rx_sync) begin
                  state_d = IDLE;
               end else begin
                  state_d         = RECEIVE;
                  framing_error_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_FIRST;
            end
         end
`endif

         RECEIVE: begin
            // Only the first packet_done cycle matters; the timer is
            // cleared as soon as we leave RECEIVE.
            if (packet_done) begin
               state_d = STOP_CHK;
               stop_d  = stop_bit;
            end
         end

         STOP_CHK: begin
            if (stop_q) begin
               state_d = LOAD;
            end else begin
               state_d         = IDLE;
               framing_error_d = 1'b1;
            end
         end

         LOAD: begin
            state_d      = IDLE;
            data_ready_d = 1'b1;
            if (data_ready_q && !data_read) begin
               overrun_error_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q         <= IDLE;
         prev_sync_q     <= 1'b1;
         stop_q          <= 1'b0;
         data_ready_q    <= 1'b0;
         framing_error_q <= 1'b0;
         overrun_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         prev_sync_q     <= prev_sync_d;
         stop_q          <= stop_d;
         data_ready_q    <= data_ready_d;
         framing_error_q <= framing_error_d;
         overrun_error_q <= overrun_error_d;
      end
   end

`ifdef RX_START_VALIDATE_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Moore outputs decoded from state; an asynchronous reset therefore
   // drops enable_timer immediately.
   assign enable_timer  = rx_state_busy(state_q) && (state_q == RECEIVE);
   assign load_buffer   = (state_q == LOAD);
   assign data_ready    = data_ready_q;
   assign framing_error = framing_error_q;
   assign overrun_error = overrun_error_q;

endmodule
